// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcode/funct values, ALU and mux encodings.
// S_JALEX only exists when MC_CTRL_JAL_EN is defined.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BEQEX,
    S_BNEEX,
    S_IMMEX,
    S_IMMWB,
    S_JEX,
    S_ILLEGAL
`ifdef MC_CTRL_JAL_EN
    ,
    S_JALEX
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_RTYPE = 4'b0010;
  localparam logic [3:0] ALU_LUI   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_AND   = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  function automatic logic [3:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ORI:  return ALU_OR;
      OP_ANDI: return ALU_AND;
      OP_XORI: return ALU_XOR;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

  // Logical immediates are zero-extended; addi (and lui, which shifts) use sign extension.
  function automatic logic imm_zeroext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mc_controller.sv
// Multicycle MIPS-style Moore controller; pcen/irwrite/memwrite also see mem_ready/zero in the current cycle.
// Define MC_CTRL_JAL_EN to add the JALEX state; otherwise jal decodes as illegal.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       zeroext,
  output logic       illegal,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic [3:0] aluop
);

  state_t state_q, state_d;
  logic   pcen_c, irwrite_c, regwrite_c, memwrite_c, illegal_c;

  // The ALU decoder resolves funct on its own; the controller never needs it.
  logic unused_funct;
  assign unused_funct = ^funct;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                               state_d = S_MEMADR;
          OP_RTYPE:                                   state_d = S_RTYPEEX;
          OP_BEQ:                                     state_d = S_BEQEX;
          OP_BNE:                                     state_d = S_BNEEX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:  state_d = S_IMMEX;
          OP_J:                                       state_d = S_JEX;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:                                     state_d = S_JALEX;
`endif
          default:                                    state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_IMMEX:   state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    pcen_c     = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    memwrite_c = 1'b0;
    illegal_c  = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    zeroext    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PCSRC_ALU;
    regdst     = REGDST_RT;
    memtoreg   = M2R_ALU;
    aluop      = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        irwrite_c = mem_ready;
        pcen_c    = mem_ready;
      end
      S_DECODE: alusrcb = SRCB_BRANCH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        regwrite_c = 1'b1;
        regdst     = REGDST_RT;
        memtoreg   = M2R_MEM;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_REG;
        aluop   = ALU_RTYPE;
      end
      S_RTYPEWB: begin
        regwrite_c = 1'b1;
        regdst     = REGDST_RD;
        memtoreg   = M2R_ALU;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_REG;
        aluop   = ALU_SUB;
        pcsrc   = PCSRC_ALUOUT;
        pcen_c  = (state_q == S_BEQEX) ? zero : ~zero;
      end
      // IMMWB keeps the ALU set up as in IMMEX so the result stays valid through the write.
      S_IMMEX, S_IMMWB: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        aluop      = imm_aluop(op);
        zeroext    = imm_zeroext(op);
        regwrite_c = (state_q == S_IMMWB);
        regdst     = REGDST_RT;
      end
      S_JEX: begin
        pcsrc  = PCSRC_JUMP;
        pcen_c = 1'b1;
      end
      S_ILLEGAL: illegal_c = 1'b1;
`ifdef MC_CTRL_JAL_EN
      S_JALEX: begin
        regwrite_c = 1'b1;
        regdst     = REGDST_R31;
        memtoreg   = M2R_PC;
        pcsrc      = PCSRC_JUMP;
        pcen_c     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Write strobes are killed the moment reset asserts, even if mem_ready is high.
  assign pcen     = pcen_c     & reset_n;
  assign irwrite  = irwrite_c  & reset_n;
  assign regwrite = regwrite_c & reset_n;
  assign memwrite = memwrite_c & reset_n;
  assign illegal  = illegal_c  & reset_n;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-state output checks and whole-instruction cycle counts.
module tb_mc_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       pcen, irwrite, regwrite, memwrite, iord, alusrca, zeroext, illegal;
  logic [1:0] alusrcb, pcsrc, regdst, memtoreg;
  logic [3:0] aluop;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite), .iord(iord),
    .alusrca(alusrca), .zeroext(zeroext), .illegal(illegal), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .regdst(regdst), .memtoreg(memtoreg), .aluop(aluop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.state_q);
  endfunction

  // Advance one cycle, apply this cycle's inputs, then settle before any check.
  task automatic tick(input logic mr, input logic z);
    @(posedge clk);
    #2;
    mem_ready = mr;
    zero      = z;
    #1;
  endtask

  // Runs one instruction from the current FETCH until the next FETCH, stalling MEMRD for 'waits' cycles.
  task automatic run_instr(input int waits, output int cycles, output int wr, output int mw,
                           output int ill, output int pc);
    int left;
    bit done;
    left = waits; cycles = 0; wr = 0; mw = 0; ill = 0; pc = 0; done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      cycles++;
      if (regwrite) wr++;
      if (memwrite) mw++;
      if (illegal)  ill++;
      if (pcen)     pc++;
      @(posedge clk);
      #2;
      zero = 1'b0;
      if (st() == 32'(S_MEMRD) && left > 0) begin
        mem_ready = 1'b0;
        left--;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (st() == 32'(S_FETCH)) done = 1;
    end
    if (!done) check("instr_timeout", 32'(cycles), 32'd0);
  endtask

  int cyc, wr, mw, ill, pc;

  initial begin
    reset_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = OP_RTYPE; funct = FUNCT_ADD;
    repeat (2) @(posedge clk);
    #3;
    check("rst_state", st(), 32'(S_FETCH));
    check("rst_pcen", 32'(pcen), 32'd0);
    check("rst_irwrite", 32'(irwrite), 32'd0);
    check("rst_regwrite", 32'(regwrite), 32'd0);
    check("rst_memwrite", 32'(memwrite), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    reset_n = 1'b1;
    #1;
    check("fetch_irwrite", 32'(irwrite), 32'd1);
    check("fetch_pcen", 32'(pcen), 32'd1);
    check("fetch_alusrcb", 32'(alusrcb), 32'b01);
    check("fetch_iord", 32'(iord), 32'd0);

    // add
    tick(1, 0);
    check("add_decode", st(), 32'(S_DECODE));
    check("decode_alusrcb", 32'(alusrcb), 32'b11);
    tick(1, 0);
    check("add_ex_state", st(), 32'(S_RTYPEEX));
    check("add_ex_aluop", 32'(aluop), 32'b0010);
    check("add_ex_srca", 32'(alusrca), 32'd1);
    check("add_ex_regwrite", 32'(regwrite), 32'd0);
    tick(1, 0);
    check("add_wb_regwrite", 32'(regwrite), 32'd1);
    check("add_wb_regdst", 32'(regdst), 32'b01);
    check("add_wb_memtoreg", 32'(memtoreg), 32'b00);
    tick(1, 0);
    check("add_back_fetch", st(), 32'(S_FETCH));

    // lw with three MEMRD wait states
    op = OP_LW;
    run_instr(3, cyc, wr, mw, ill, pc);
    check("lw_cycles", 32'(cyc), 32'd8);
    check("lw_regwrites", 32'(wr), 32'd1);

    // lw, zero wait
    run_instr(0, cyc, wr, mw, ill, pc);
    check("lw0_cycles", 32'(cyc), 32'd5);

    // sw, zero wait
    op = OP_SW;
    run_instr(0, cyc, wr, mw, ill, pc);
    check("sw_cycles", 32'(cyc), 32'd4);
    check("sw_memwrites", 32'(mw), 32'd1);
    check("sw_regwrites", 32'(wr), 32'd0);

    // ori
    op = OP_ORI;
    tick(1, 0);
    tick(1, 0);
    check("ori_ex_aluop", 32'(aluop), 32'b0100);
    check("ori_ex_zeroext", 32'(zeroext), 32'd1);
    check("ori_ex_srcb", 32'(alusrcb), 32'b10);
    tick(1, 0);
    check("ori_wb_aluop", 32'(aluop), 32'b0100);
    check("ori_wb_zeroext", 32'(zeroext), 32'd1);
    check("ori_wb_regwrite", 32'(regwrite), 32'd1);
    check("ori_wb_regdst", 32'(regdst), 32'b00);
    tick(1, 0);

    // lui
    op = OP_LUI;
    tick(1, 0);
    tick(1, 0);
    check("lui_ex_aluop", 32'(aluop), 32'b0011);
    check("lui_ex_zeroext", 32'(zeroext), 32'd0);
    tick(1, 0);
    tick(1, 0);
    check("lui_back_fetch", st(), 32'(S_FETCH));

    // beq taken, bne not taken, bne taken
    op = OP_BEQ;
    tick(1, 0);
    tick(1, 1);
    check("beq_pcen", 32'(pcen), 32'd1);
    check("beq_pcsrc", 32'(pcsrc), 32'b01);
    check("beq_aluop", 32'(aluop), 32'b0001);
    tick(1, 0);
    check("beq_back_fetch", st(), 32'(S_FETCH));
    op = OP_BNE;
    tick(1, 0);
    tick(1, 1);
    check("bne_z1_pcen", 32'(pcen), 32'd0);
    check("bne_pcsrc", 32'(pcsrc), 32'b01);
    tick(1, 0);
    tick(1, 0);
    tick(1, 0);
    check("bne_z0_pcen", 32'(pcen), 32'd1);
    tick(1, 0);

    // j
    op = OP_J;
    run_instr(0, cyc, wr, mw, ill, pc);
    check("j_cycles", 32'(cyc), 32'd3);
    check("j_pcen_cycles", 32'(pc), 32'd2);

    // op 111111
    op = 6'b111111;
    run_instr(0, cyc, wr, mw, ill, pc);
    check("ill_cycles", 32'(cyc), 32'd3);
    check("ill_pulses", 32'(ill), 32'd1);
    check("ill_regwrites", 32'(wr), 32'd0);

    // jal
    op = OP_JAL;
    tick(1, 0);
    tick(1, 0);
`ifdef MC_CTRL_JAL_EN
    check("jal_regdst", 32'(regdst), 32'b10);
    check("jal_regwrite", 32'(regwrite), 32'd1);
    check("jal_memtoreg", 32'(memtoreg), 32'b10);
    check("jal_pcen", 32'(pcen), 32'd1);
    check("jal_illegal", 32'(illegal), 32'd0);
`else
    check("jal_illegal", 32'(illegal), 32'd1);
    check("jal_regwrite", 32'(regwrite), 32'd0);
`endif
    tick(1, 0);
    check("jal_back_fetch", st(), 32'(S_FETCH));

    // FETCH stalls while memory is not ready
    mem_ready = 1'b0;
    #1;
    check("fetch_stall_irwrite", 32'(irwrite), 32'd0);
    check("fetch_stall_pcen", 32'(pcen), 32'd0);
    tick(1, 0);
    check("fetch_stall_state", st(), 32'(S_FETCH));
    check("fetch_ready_irwrite", 32'(irwrite), 32'd1);

    // reset during a stalled MEMWR
    op = OP_SW;
    tick(1, 0);
    tick(1, 0);
    tick(0, 0);
    check("memwr_memwrite", 32'(memwrite), 32'd1);
    check("memwr_iord", 32'(iord), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_memwrite", 32'(memwrite), 32'd0);
    check("rstmid_state", st(), 32'(S_FETCH));
    mem_ready = 1'b1;
    @(posedge clk);
    #2;
    check("rstmid_irwrite", 32'(irwrite), 32'd0);
    check("rstmid_pcen", 32'(pcen), 32'd0);
    reset_n = 1'b1;
    #1;
    check("release_state", st(), 32'(S_FETCH));
    tick(1, 0);
    check("release_decode", st(), 32'(S_DECODE));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes occur on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports op and funct, input, 6 bits each: fields of the latched instruction register.
REQ-004 SHALL have ports zero, input, 1 bit (ALU zero flag), and mem_ready, input, 1 bit (memory access completes this cycle).
REQ-005 SHALL have outputs pcen, irwrite, regwrite, memwrite, iord, alusrca, zeroext and illegal, each 1 bit.
REQ-006 SHALL have 2-bit outputs alusrcb, pcsrc, regdst (00 rt, 01 rd, 10 r31) and memtoreg (00 ALU, 01 memory, 10 PC).
REQ-007 SHALL have output aluop, 4 bits, driven to the ALU decoder: 0000 add, 0001 sub, 0010 R-type, 0011 lui, 0100 or, 0101 and, 0111 xor.

Function
REQ-008 SHALL be a Moore FSM; all outputs SHALL decode from the state register only, except pcen, irwrite and memwrite (see below); unlisted outputs are 0.
REQ-009 FETCH SHALL drive iord=0, alusrca=0, alusrcb=01, aluop=0000 and pcsrc=00; it SHALL hold until mem_ready=1, then assert irwrite=1 and pcen=1 in that cycle and go to DECODE.
REQ-010 DECODE SHALL drive alusrca=0, alusrcb=11 and aluop=0000 (branch target).
REQ-011 DECODE SHALL branch by op: lw/sw to MEMADR; 000000 to RTYPEEX; beq to BEQEX; bne to BNEEX; addi/andi/ori/xori/lui to IMMEX; j to JEX; jal as in REQ-022; anything else to ILLEGAL.
REQ-012 MEMADR SHALL drive alusrca=1, alusrcb=10 and aluop=0000, then go to MEMRD for lw or MEMWR for sw.
REQ-013 MEMRD SHALL drive iord=1 and wait for mem_ready=1, then go to MEMWB; MEMWB SHALL drive regwrite=1, regdst=00 and memtoreg=01, then go to FETCH.
REQ-014 MEMWR SHALL drive iord=1 and memwrite=1 every cycle until mem_ready=1, then go to FETCH.
REQ-015 RTYPEEX SHALL drive alusrca=1, alusrcb=00 and aluop=0010, then go to RTYPEWB; RTYPEWB SHALL drive regwrite=1, regdst=01 and memtoreg=00, then go to FETCH.
REQ-016 BEQEX/BNEEX SHALL drive alusrca=1, alusrcb=00, aluop=0001 and pcsrc=01, with pcen=zero (BEQ) or pcen=~zero (BNE), then go to FETCH.
REQ-017 IMMEX SHALL drive alusrca=1 and alusrcb=10, plus aluop by op: addi 0000, ori 0100, andi 0101, xori 0111, lui 0011.
REQ-018 IMMEX SHALL drive zeroext=1 for andi/ori/xori; IMMWB SHALL hold the same aluop, zeroext and ALU source values, add regwrite=1 and regdst=00, then go to FETCH.
REQ-019 JEX SHALL drive pcsrc=10 and pcen=1, then go to FETCH.
REQ-020 ILLEGAL SHALL pulse illegal=1 for exactly one cycle, write nothing, then go to FETCH; the PC is already incremented.
REQ-021 Latency: R-type and immediate instructions SHALL take 4 cycles, branch and jump 3, lw 5 and sw 4 (zero wait states); each mem_ready=0 cycle SHALL add one cycle.

Configuration
REQ-022 With MC_CTRL_JAL_EN defined, op 000011 SHALL go to JALEX: regwrite=1, regdst=10, memtoreg=10, pcsrc=10, pcen=1, then FETCH; without the macro, jal SHALL go to ILLEGAL and the JALEX state SHALL not exist.

Reset
REQ-023 While reset_n=0, the state SHALL be FETCH and pcen, irwrite, regwrite, memwrite and illegal SHALL be forced to 0, regardless of mem_ready.
REQ-024 Reset asserted mid-instruction SHALL abandon the instruction with no further writes.
REQ-025 The first FETCH SHALL begin on the first rising edge after reset_n goes high.

Structure
REQ-026 The state enum, opcode/funct constants and aluop encodings SHALL live in shared package mc_pkg.
REQ-027 No sub-module SHALL be created; the aluop output SHALL feed the existing ALU decoder unchanged.

Verification
REQ-028 add (op 000000), mem_ready=1: states FETCH, DECODE, RTYPEEX, RTYPEWB; aluop=0010 in RTYPEEX; regwrite=1 with regdst=01 in cycle 4 only.
REQ-029 lw with mem_ready held low 3 cycles in MEMRD: 8 cycles total; regwrite=1 with memtoreg=01 exactly once.
REQ-030 beq with zero=1 gives pcen=1 and pcsrc=01 in BEQEX; bne with zero=1 gives pcen=0.
REQ-031 ori: aluop=0100 and zeroext=1 in IMMEX and IMMWB; lui: aluop=0011 and zeroext=0.
REQ-032 op 111111, then jal, run both with and without MC_CTRL_JAL_EN: illegal pulses once for 111111; for jal, regdst=10 with the macro and illegal=1 without it.
REQ-033 reset_n pulled low during MEMWR while mem_ready=0: memwrite drops immediately; after release the controller is in FETCH.
